// File: rtl/serial_add_sub_ctrl_pkg.sv
// Shared encodings for the bit-serial add/sub controller.
package serial_add_sub_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/serial_add_sub_ctrl_full_adder.sv
// 1-bit full adder cell shared across all bit positions by the serial controller.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic s_out,
  output logic c_out
);

  always_comb begin
    s_out = a ^ b ^ c_in;
    c_out = (a & b) | (a & c_in) | (b & c_in);
  end

endmodule

// File: rtl/serial_add_sub_ctrl.sv
// Bit-serial adder/subtractor: one full_adder sequenced LSB-first over WIDTH cycles,
// with start/busy/done handshake and held result/carry/overflow registers.
module serial_add_sub_ctrl
  import serial_add_sub_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             sub_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             carry_o,
  output logic             overflow_o
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_sh, b_sh, sum_sh;
  logic             carry_q;
  logic [CNT_W-1:0] cnt_q;
  logic             fa_s, fa_c;
  logic             accept, last_bit;

  full_adder u_fa (
    .a     (a_sh[0]),
    .b     (b_sh[0]),
    .c_in  (carry_q),
    .s_out (fa_s),
    .c_out (fa_c)
  );

  // A new request is only taken when not running; DONE accepts like IDLE.
  always_comb begin
    accept   = start_i && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    last_bit = (state_q == ST_RUN) && (cnt_q == CNT_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_RUN;
      ST_RUN:  if (last_bit) state_d = ST_DONE;
      ST_DONE: state_d = accept ? ST_RUN : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_o = (state_q == ST_RUN);
    done_o = (state_q == ST_DONE);
  end

  // Subtraction is a + ~b + 1: the +1 enters as the initial carry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh    <= '0;
      b_sh    <= '0;
      sum_sh  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else if (accept) begin
      a_sh    <= a_i;
      b_sh    <= (sub_i == OP_SUB) ? ~b_i : b_i;
      carry_q <= sub_i;
      cnt_q   <= '0;
    end else if (state_q == ST_RUN) begin
      a_sh    <= {1'b0, a_sh[WIDTH-1:1]};
      b_sh    <= {1'b0, b_sh[WIDTH-1:1]};
      sum_sh  <= {fa_s, sum_sh[WIDTH-1:1]};
      carry_q <= fa_c;
      cnt_q   <= last_bit ? '0 : cnt_q + 1'b1;
    end
  end

  // carry_q during the MSB step is the carry into the MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_o   <= '0;
      carry_o    <= 1'b0;
      overflow_o <= 1'b0;
    end else if (last_bit) begin
      result_o   <= {fa_s, sum_sh[WIDTH-1:1]};
      carry_o    <= fa_c;
      overflow_o <= carry_q ^ fa_c;
    end
  end

endmodule
